// File: rtl/bist_misr_analyzer_pkg.sv
// Shared BIST package.
// Holds the MISR/pattern-generator feedback polynomial, the pattern counter
// width and the analyzer FSM state encoding.
package bist_misr_analyzer_pkg;

  // x^8 + x^4 + x^3 + x^2 + 1. The pattern generator LFSR uses the same taps.
  localparam logic [7:0] POLY_8 = 8'h1D;

  localparam int PAT_CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/bist_misr_analyzer_if.sv
// Bus between the BIST controller / CUT and the output response analyzer.
//   start       controller -> analyzer  one-cycle run request
//   resp_valid  CUT -> analyzer         resp_data holds a response this cycle
//   resp_data   CUT -> analyzer         response word
//   busy/done/pass, signature, pat_count  analyzer -> controller status
//
// Handshake: valid-only, no back-pressure. A word is transferred on every
// rising clock edge where resp_valid=1 and the analyzer is in RUN; words
// presented in IDLE or DONE are dropped. resp_valid may be low for any number
// of cycles between words.
interface bist_misr_analyzer_if
  import bist_misr_analyzer_pkg::*;
#(
  parameter int WIDTH = 8
);

  logic                 start;
  logic                 resp_valid;
  logic [WIDTH-1:0]     resp_data;
  logic                 busy;
  logic                 done;
  logic                 pass;
  logic [WIDTH-1:0]     signature;
  logic [PAT_CNT_W-1:0] pat_count;

  modport master (
    output start, resp_valid, resp_data,
    input  busy, done, pass, signature, pat_count
  );

  modport slave (
    input  start, resp_valid, resp_data,
    output busy, done, pass, signature, pat_count
  );

endinterface

// File: rtl/bist_misr_analyzer_core.sv
// Pure WIDTH-bit multiple-input signature register.
//   clk, rst   clock / async active-high reset (register <- SEED)
//   load       synchronous reload to SEED (has priority over en)
//   en         compress d into the register this cycle
//   d          input word
//   sig        current register contents
//   sig_next   value the register takes if en is asserted this cycle
module bist_misr_core #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] POLY  = 8'h1D,
  parameter logic [WIDTH-1:0] SEED  = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] sig,
  output logic [WIDTH-1:0] sig_next
);

  // Galois-style step: shift up, fold the MSB back in through the taps,
  // then XOR in the parallel data word. All modulo-2, no carries.
  always_comb begin
    sig_next    = '0;
    sig_next[0] = (sig[WIDTH-1] & POLY[0]) ^ d[0];
    for (int i = 1; i < WIDTH; i++) begin
      sig_next[i] = sig[i-1] ^ (sig[WIDTH-1] & POLY[i]) ^ d[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sig <= SEED;
    end else if (load) begin
      sig <= SEED;
    end else if (en) begin
      sig <= sig_next;
    end
  end

endmodule

// File: rtl/bist_misr_analyzer.sv
// BIST output response analyzer.
// Compresses N_PATTERNS accepted CUT responses into a MISR signature, then
// compares the signature with GOLDEN and reports done/pass.
//   clk, rst    clock / async active-high reset
//   bus         analyzer side of bist_misr_analyzer_if (start, resp_*, status)
//   dbg_state   current FSM state, for observation only
module bist_misr_analyzer
  import bist_misr_analyzer_pkg::*;
#(
  parameter int               WIDTH      = 8,
  parameter logic [WIDTH-1:0] POLY       = POLY_8,
  parameter logic [WIDTH-1:0] SEED       = 8'h00,
  parameter int               N_PATTERNS = 255,
  parameter logic [WIDTH-1:0] GOLDEN     = 8'h00
) (
  input  logic                    clk,
  input  logic                    rst,
  bist_misr_analyzer_if.slave     bus,
  output state_t                  dbg_state
);

  localparam logic [PAT_CNT_W-1:0] LAST_IDX = PAT_CNT_W'(N_PATTERNS - 1);

  state_t               state_q, state_d;
  logic                 load, en;
  logic [PAT_CNT_W-1:0] pat_count_q;
  logic                 pass_q;
  logic [WIDTH-1:0]     sig, sig_next;

  bist_misr_core #(
    .WIDTH (WIDTH),
    .POLY  (POLY),
    .SEED  (SEED)
  ) u_core (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .en       (en),
    .d        (bus.resp_data),
    .sig      (sig),
    .sig_next (sig_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // start is only honoured from IDLE or DONE; resp_valid only in RUN.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    en      = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          load    = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (bus.resp_valid) begin
          en = 1'b1;
          if (pat_count_q == LAST_IDX) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (bus.start) begin
          load    = 1'b1;
          state_d = RUN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pat_count_q <= '0;
    end else if (load) begin
      pat_count_q <= '0;
    end else if (en) begin
      pat_count_q <= pat_count_q + 1'b1;
    end
  end

  // pass is judged on the signature the final step produces, so it is valid
  // in the same cycle done rises and then held until the next start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pass_q <= 1'b0;
    end else if (load) begin
      pass_q <= 1'b0;
    end else if (en && (state_d == DONE)) begin
      pass_q <= (sig_next == GOLDEN);
    end
  end

  assign bus.busy      = (state_q == RUN);
  assign bus.done      = (state_q == DONE);
  assign bus.pass      = pass_q;
  assign bus.signature = sig;
  assign bus.pat_count = pat_count_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_bist_misr_analyzer.sv
// Bench for bist_misr_analyzer. Three analyzers with different parameter sets
// are driven one at a time by directed steps:
//   0: N_PATTERNS=1,  SEED=00, GOLDEN=5A
//   1: N_PATTERNS=2,  SEED=00, GOLDEN=1D
//   2: N_PATTERNS=10, SEED=80, GOLDEN=00
module tb_bist_misr_analyzer;
  import bist_misr_analyzer_pkg::*;

  localparam int NI = 3;

  function automatic int np_of(input int k);
    return (k == 0) ? 1 : (k == 1) ? 2 : 10;
  endfunction

  function automatic logic [7:0] seed_of(input int k);
    return (k == 2) ? 8'h80 : 8'h00;
  endfunction

  function automatic logic [7:0] golden_of(input int k);
    return (k == 0) ? 8'h5A : (k == 1) ? 8'h1D : 8'h00;
  endfunction

  // Reference MISR: multiply by x modulo x^8+x^4+x^3+x^2+1, then add data.
  function automatic logic [7:0] misr_ref(input logic [7:0] s, input logic [7:0] d);
    return {s[6:0], 1'b0} ^ (s[7] ? 8'h1D : 8'h00) ^ d;
  endfunction

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- DUTs ----------------
  logic [NI-1:0]        start_v, valid_v;
  logic [NI-1:0][7:0]   data_v;
  logic [NI-1:0]        busy_v, done_v, pass_v;
  logic [NI-1:0][7:0]   sig_v;
  logic [NI-1:0][15:0]  cnt_v;
  state_t               st_v [NI];

  for (genvar k = 0; k < NI; k++) begin : g_dut
    bist_misr_analyzer_if #(.WIDTH(8)) bus ();

    bist_misr_analyzer #(
      .WIDTH      (8),
      .POLY       (8'h1D),
      .SEED       (seed_of(k)),
      .N_PATTERNS (np_of(k)),
      .GOLDEN     (golden_of(k))
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .dbg_state (st_v[k])
    );

    assign bus.start      = start_v[k];
    assign bus.resp_valid = valid_v[k];
    assign bus.resp_data  = data_v[k];
    assign busy_v[k]      = bus.busy;
    assign done_v[k]      = bus.done;
    assign pass_v[k]      = bus.pass;
    assign sig_v[k]       = bus.signature;
    assign cnt_v[k]       = bus.pat_count;
  end

  // ---------------- scoreboard ----------------
  int         n_checks;
  int         n_errors;
  logic [7:0] exp_q[$];
  logic [7:0] exp_sig [NI];
  int         exp_cnt [NI];
  logic [7:0] pats [10];
  logic [7:0] ref_sig;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_status(input int k, input string tag, input logic eb,
                              input logic ed, input logic ep);
    chk({tag, ".busy"}, 32'(busy_v[k]), 32'(eb));
    chk({tag, ".done"}, 32'(done_v[k]), 32'(ed));
    chk({tag, ".pass"}, 32'(pass_v[k]), 32'(ep));
    chk({tag, ".cnt"},  32'(cnt_v[k]),  32'(exp_cnt[k]));
  endtask

  task automatic start_run(input int k, input string tag);
    start_v[k] = 1'b1;
    step();
    start_v[k] = 1'b0;
    exp_sig[k] = seed_of(k);
    exp_cnt[k] = 0;
    check_status(k, tag, 1'b1, 1'b0, 1'b0);
    chk({tag, ".sig"},   32'(sig_v[k]), 32'(exp_sig[k]));
    chk({tag, ".state"}, 32'(st_v[k]),  32'(RUN));
  endtask

  task automatic send(input int k, input logic [7:0] d, input string tag);
    logic [7:0] e;
    valid_v[k] = 1'b1;
    data_v[k]  = d;
    exp_sig[k] = misr_ref(exp_sig[k], d);
    exp_q.push_back(exp_sig[k]);
    exp_cnt[k]++;
    step();
    valid_v[k] = 1'b0;
    e = exp_q.pop_front();
    chk({tag, ".sig"}, 32'(sig_v[k]), 32'(e));
    if (exp_cnt[k] == np_of(k))
      check_status(k, tag, 1'b0, 1'b1, (exp_sig[k] == golden_of(k)));
    else
      check_status(k, tag, 1'b1, 1'b0, 1'b0);
  endtask

  // n cycles with no accepted data; v drives resp_valid, s pulses start on
  // the first cycle. Everything observable must hold.
  task automatic hold(input int k, input int n, input logic v, input logic s,
                      input logic eb, input logic ed, input string tag);
    for (int i = 0; i < n; i++) begin
      valid_v[k] = v;
      start_v[k] = s && (i == 0);
      data_v[k]  = 8'($urandom_range(0, 255));
      step();
      chk({tag, ".sig"}, 32'(sig_v[k]), 32'(exp_sig[k]));
      check_status(k, tag, eb, ed, ed && (exp_sig[k] == golden_of(k)));
    end
    valid_v[k] = 1'b0;
    start_v[k] = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    n_checks = 0;
    n_errors = 0;
    rst      = 1'b1;
    start_v  = '0;
    valid_v  = '0;
    data_v   = '0;
    step();
    step();

    for (int k = 0; k < NI; k++) begin
      exp_sig[k] = seed_of(k);
      exp_cnt[k] = 0;
      check_status(k, "reset", 1'b0, 1'b0, 1'b0);
      chk("reset.sig",   32'(sig_v[k]), 32'(seed_of(k)));
      chk("reset.state", 32'(st_v[k]),  32'(IDLE));
    end
    rst = 1'b0;
    step();

    // Single pattern, resp_valid ignored in IDLE and DONE, back-to-back runs.
    hold(0, 2, 1'b1, 1'b0, 1'b0, 1'b0, "idle_valid");
    start_run(0, "p1_start");
    send(0, 8'h5A, "p1_data");
    chk("p1_const", 32'(sig_v[0]), 32'h5A);
    hold(0, 2, 1'b1, 1'b0, 1'b0, 1'b1, "done_valid");
    start_run(0, "p1_restart");
    send(0, 8'h5A, "p1_again");
    start_run(0, "p1_restart2");
    send(0, 8'h11, "p1_badsig");

    // Two patterns with a gap; start in RUN ignored.
    start_run(1, "p2_start");
    send(1, 8'h80, "p2_w0");
    hold(1, 3, 1'b0, 1'b1, 1'b1, 1'b0, "p2_gap");
    send(1, 8'h00, "p2_w1");
    chk("p2_const", 32'(sig_v[1]), 32'h1D);
    chk("p2_pass",  32'(pass_v[1]), 32'h1);
    start_run(1, "p2_rerun");
    send(1, 8'h80, "p2_r0");
    send(1, 8'h01, "p2_r1");
    chk("p2_fail_sig",  32'(sig_v[1]), 32'h1C);
    chk("p2_fail_pass", 32'(pass_v[1]), 32'h0);

    // Feedback taps from SEED=80, then reset mid-run.
    for (int i = 0; i < 10; i++) pats[i] = 8'($urandom_range(0, 255));
    pats[0] = 8'h00;
    start_run(2, "p10_start");
    send(2, pats[0], "p10_tap");
    chk("tap_const", 32'(sig_v[2]), 32'h1D);
    for (int i = 1; i < 5; i++) send(2, pats[i], "p10_pre");

    rst = 1'b1;
    #1;
    for (int k = 0; k < NI; k++) begin
      exp_sig[k] = seed_of(k);
      exp_cnt[k] = 0;
    end
    check_status(2, "midrst", 1'b0, 1'b0, 1'b0);
    chk("midrst.sig",   32'(sig_v[2]), 32'h80);
    chk("midrst.state", 32'(st_v[2]),  32'(IDLE));
    step();
    rst = 1'b0;
    step();

    ref_sig = 8'h80;
    for (int i = 0; i < 10; i++) ref_sig = misr_ref(ref_sig, pats[i]);

    start_run(2, "p10_run1");
    for (int i = 0; i < 10; i++) send(2, pats[i], "p10_run1");
    chk("p10_run1_final", 32'(sig_v[2]), 32'(ref_sig));
    start_run(2, "p10_run2");
    for (int i = 0; i < 10; i++) send(2, pats[i], "p10_run2");
    chk("p10_run2_final", 32'(sig_v[2]), 32'(ref_sig));
    chk("sb_empty", 32'(exp_q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/bist_misr_analyzer.md
Name: bist_misr_analyzer

Overview:
- Output response analyzer for the BIST chain. Sits downstream of the circuit-under-test, which is driven by the pattern-generator LFSR.
- Compresses one CUT response word per valid cycle into a multiple-input signature register (MISR) over a fixed number of patterns.
- After the last pattern, compares the signature against a golden value and reports done/pass to the BIST controller.

Parameters:
- WIDTH, 8, response/signature width in bits.
- POLY, 8'h1D, MISR feedback taps (x^8+x^4+x^3+x^2+1), the same polynomial as the pattern generator; bit i set means feedback XORs into bit i.
- SEED, 8'h00, signature value loaded on reset and on start.
- N_PATTERNS, 255, number of valid responses compressed per run; legal range 1..65535.
- GOLDEN, 8'h00, expected final signature.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  one-cycle pulse; begins a run from IDLE or DONE.
- resp_valid  in  1  resp_data is a valid CUT response this cycle.
- resp_data  in  WIDTH  CUT response word.
- busy  out  1  high while in RUN.
- done  out  1  high while in DONE.
- pass  out  1  valid only when done=1: 1 if signature==GOLDEN.
- signature  out  WIDTH  current MISR contents.
- pat_count  out  16  number of responses compressed in the current run.

Behaviour:
- Reset (async, any state including mid-run): state=IDLE, signature=SEED, pat_count=0, busy=0, done=0, pass=0.
- MISR step, taken on every accepted response; fb=sig[WIDTH-1]:
  - next[0] = (fb & POLY[0]) ^ d[0]
  - next[i] = sig[i-1] ^ (fb & POLY[i]) ^ d[i], for i=1..WIDTH-1
- FSM states IDLE, RUN, DONE:
  - IDLE: resp_valid ignored. start -> load signature=SEED and pat_count=0, go to RUN next cycle.
  - RUN: busy=1. A response is accepted only on cycles in RUN with resp_valid=1; a start in the same cycle as the IDLE->RUN transition does not compress data. On resp_valid=1: MISR step and pat_count+1. When resp_valid=1 and pat_count==N_PATTERNS-1: final step taken and go to DONE. resp_valid=0 holds signature and count (gaps allowed, unbounded). start is ignored in RUN.
  - DONE: done=1, pass=(signature==GOLDEN), registered, asserted in the same cycle done rises. signature, pat_count and pass are held. resp_valid ignored. start -> reload SEED, clear count, clear done/pass, go to RUN.
- Latency:
  - Signature reflects an accepted word one cycle after acceptance.
  - done rises the cycle after the final accepted word.
- Width rules:
  - pat_count is 16 bits unsigned and never wraps, because RUN exits at N_PATTERNS.
  - The MISR is modulo-2 with no carries.
- Simultaneous start and rst: rst wins.

Decomposition:
- Shared BIST package holds:
  - the polynomial constant POLY_8 = 8'h1D, also used by the pattern generator;
  - the FSM state encoding (IDLE=2'b00, RUN=2'b01, DONE=2'b10).
- One natural sub-module: bist_misr_core, the pure WIDTH-bit MISR register with load/enable/data inputs. The top keeps the FSM, counter and compare.

Test Plan:
- Single-pattern compression: N_PATTERNS=1, SEED=0; start, then resp_valid with 0x5A -> signature=0x5A, done=1 the next cycle, pass=1 when GOLDEN=0x5A.
- Feedback tap check: SEED=8'h80, N_PATTERNS=1; compress data 0x00 -> signature=0x1D, which confirms taps 0, 2, 3 and 4.
- Two patterns with a valid gap: SEED=0, N_PATTERNS=2; send 0x80, idle 3 cycles with resp_valid=0, then send 0x00 -> signature stays 0x80 during the gap, final 0x1D. GOLDEN=0x1D -> pass=1; rerun with GOLDEN=0x1C -> pass=0 with done=1.
- Protocol filtering: pulse start during RUN, and drive resp_valid in IDLE and in DONE -> no restart, pat_count and signature unchanged.
- Reset mid-run: assert rst after 5 of 10 patterns -> immediately busy=0, signature=SEED, pat_count=0. A subsequent start/run produces the same signature as an uninterrupted run.
- Back-to-back runs: start in DONE -> done and pass drop the next cycle, signature=SEED, and the second identical stimulus yields an identical signature.
